srm_wta_column: RTL and testbench
=================================

# srm_wta_column

Excitatory column stage directly upstream of the STDP learning block. Each neuron integrates its synapses' temporally coded input spikes with a ramp-no-leak response shaped by thermometer-coded weights. A neuron fires when its body potential reaches threshold, and lateral 1-winner-take-all inhibition is applied. The active-low output spike lines feed the STDP block's `output_spikes` input, and the STDP block's weights feed back into this block.

## Interface
- `NEURONS`, default 2: neurons in the column.
- `SYNAPSES`, default 2: synapses per neuron.
- `THRESHOLD`, default 4: firing threshold on body potential.
- `` `TIME_PERIOD ``, from `internal_defines.vh`: gamma-cycle length in clocks. Must be a power of two.
- `PW = $clog2(SYNAPSES*`TIME_PERIOD+1)`: potential width (localparam).

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `cycle`, in, `$clog2(`TIME_PERIOD)`: gamma-cycle position from the shared free-running up counter.
- `input_spikes`, in, `[NEURONS][SYNAPSES]`: active-low step-coded spikes.
- `weights`, in, `[NEURONS][SYNAPSES][`TIME_PERIOD]`: thermometer weights, LSB-first.
- `output_spikes`, out, `[NEURONS]`: active-low step-coded output spikes.
- `fire_valid`, out, 1: one-cycle pulse when a firing is registered.
- `winner_idx`, out, `$clog2(NEURONS)` (min 1): index of the neuron that fired. Valid with `fire_valid`.

## Operation
- Per neuron-synapse state:
  - `active` latch: set the first cycle `input_spikes[n][s]==0`. Stays set for the rest of the period even if the line returns high.
  - `age` counter: 0 in the first active cycle, +1 per cycle while active, saturates at `TIME_PERIOD-1`.
- Per-cycle increment: `inc[n] = Σ_s (active_or_low[n][s] ? weights[n][s][age] : 0)`. Here `age` is 0 in the cycle the spike first appears.
  - Response = min(k+1, popcount(w)) at k cycles after the spike.
- Potential: `pot[n] <= pot[n] + inc[n]`, `PW` bits. It cannot overflow by construction.
- Fire condition: `pot[n]+inc[n] >= THRESHOLD` and the neuron has not fired this period.
- Firing sets `output_spikes[n]` to 0. It stays 0 until the period ends.
- One firing per neuron per period.
- Period end: on the edge ending `cycle==`TIME_PERIOD-1`, clear all `active`, `age`, `pot` and fired flags, and set `output_spikes` to all ones.
  - Inputs and fire conditions in that last cycle are ignored. The earliest output spike is therefore cycle 1 and the latest is cycle `TIME_PERIOD-1`.
- WTA (see Configuration):
  - Among neurons meeting the fire condition in the same cycle, the lowest index wins.
  - After any neuron fires, all others are inhibited for the rest of the period.

## Timing
- Reset values: `output_spikes='1`, `fire_valid=0`, `winner_idx=0`, and all internal state zero.
- Reset takes effect immediately, including mid-period. After release, operation resumes at whatever `cycle` value is present, from cleared state.
- Latency: a fire condition met in cycle c gives `output_spikes[n]==0`, `fire_valid==1` and `winner_idx==n` in cycle c+1. `fire_valid` drops in cycle c+2.
- All outputs are registered. No combinational path runs from inputs to outputs.
- A spike arriving in the same cycle as the fire evaluation contributes to it.
- Simultaneous crossings are resolved by the index priority above.

## Configuration
- `SRM_WTA_EN` defined: 1-WTA inhibition as described. At most one output line is low per period.
- `SRM_WTA_EN` undefined: no inhibition. Every neuron fires independently when its own condition is met.
  - `fire_valid` pulses on any firing.
  - `winner_idx` reports the lowest index among the neurons that fired in that cycle.

## Test plan
Test parameters: `TIME_PERIOD=8`, `NEURONS=2`, `SYNAPSES=2`, `THRESHOLD=4`. Weight values are 8-bit thermometer codes.

- **Reset:** hold `rst_n=0` with random inputs. Required: `output_spikes=2'b11`, `fire_valid=0`. Same result when `rst_n` is asserted in cycle 3 of an active period.
- **Basic fire:** neuron0 weights `8'b00000011` on both synapses, neuron1 weights 0. Both neuron0 inputs go low in cycle 1; synapse 1 returns high in cycle 2. Required: `output_spikes=2'b10` from cycle 3 through cycle 7, `fire_valid` pulses in cycle 3 with `winner_idx=0`, and `2'b11` is back in cycle 0 of the next period.
- **Sub-threshold:** all weights `8'b00000001`, all inputs low from cycle 0. Required: potential saturates at 2 and `output_spikes` stays `2'b11` for the whole period.
- **Tie:** both neurons use the weights from the basic-fire case with identical spikes. With `SRM_WTA_EN` defined: `2'b10` from cycle 3. Without it: `2'b00` from cycle 3, `winner_idx=0`.
- **Late loser:** neuron1 crosses in cycle 5 after neuron0 fired in cycle 2. With `SRM_WTA_EN` defined: `output_spikes[1]` stays 1.
- **Last-cycle and back-to-back:** a spike in cycle 7 only is ignored, with no fire in the next period from it. 75 consecutive periods of the basic-fire stimulus each produce exactly one `fire_valid` pulse in cycle 3.

Source files
------------

// File: rtl/srm_wta_column.sv
// srm_wta_column
//   Excitatory SRM column with ramp-no-leak synaptic response and optional
//   1-winner-take-all lateral inhibition. Each neuron accumulates
//   weights[n][s][age] for every synapse that has spiked this gamma period.
//   A neuron fires, at most once per period, when pot + inc reaches THRESHOLD.
//   All state clears on the edge that ends cycle == TIME_PERIOD-1.
//
//   Build option: define SRM_WTA_EN for 1-WTA inhibition, where only the
//   lowest-index candidate fires and the rest are inhibited for the period.
//   Without it, every neuron fires independently.
//   TIME_PERIOD normally comes from internal_defines.vh. It must be a
//   power of two and at least 2.
//
// Ports
//   clk            clock
//   rst_n          asynchronous active-low reset
//   cycle          position in the gamma period (shared free-running counter)
//   input_spikes   [NEURONS][SYNAPSES] active-low step-coded input spikes
//   weights        [NEURONS][SYNAPSES][TIME_PERIOD] thermometer weights, LSB first
//   output_spikes  [NEURONS] active-low step-coded output spikes (registered)
//   fire_valid     one-cycle pulse when a firing is registered
//   winner_idx     lowest index that fired; valid with fire_valid
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module srm_wta_column #(
  parameter int NEURONS   = 2,
  parameter int SYNAPSES  = 2,
  parameter int THRESHOLD = 4,
  localparam int TP = `TIME_PERIOD,
  localparam int AW = $clog2(TP),
  localparam int PW = $clog2(SYNAPSES * TP + 1),
  localparam int WW = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [AW-1:0]                          cycle,
  input  logic [NEURONS-1:0][SYNAPSES-1:0]       input_spikes,
  input  logic [NEURONS-1:0][SYNAPSES-1:0][TP-1:0] weights,
  output logic [NEURONS-1:0]                     output_spikes,
  output logic                                   fire_valid,
  output logic [WW-1:0]                          winner_idx
);

  logic [NEURONS-1:0][SYNAPSES-1:0]         active;
  logic [NEURONS-1:0][SYNAPSES-1:0][AW-1:0] age;
  logic [NEURONS-1:0][PW-1:0]               pot;

  logic [NEURONS-1:0][PW-1:0] inc;
  logic [NEURONS-1:0][PW-1:0] sum;
  logic [NEURONS-1:0]         cand;
  logic [NEURONS-1:0]         fire;
  logic [WW-1:0]              win;
  logic [AW-1:0]              idx;
  logic                       last;

  // Integration and fire candidates. A synapse whose line is low this cycle
  // counts as active with age 0, so a fresh spike contributes immediately.
  always_comb begin
    last = (cycle == AW'(TP - 1));
    inc  = '0;
    sum  = '0;
    cand = '0;
    idx  = '0;
    for (int unsigned n = 0; n < NEURONS; n++) begin
      for (int unsigned s = 0; s < SYNAPSES; s++) begin
        idx = active[n][s] ? age[n][s] : '0;
        if ((active[n][s] || !input_spikes[n][s]) && weights[n][s][idx])
          inc[n] = inc[n] + PW'(1);
      end
      sum[n]  = pot[n] + inc[n];
      // output_spikes[n] high means the neuron has not fired this period
      cand[n] = (int'(sum[n]) >= THRESHOLD) && output_spikes[n] && !last;
    end
  end

`ifdef SRM_WTA_EN
  logic inhibit;
  logic taken;

  always_comb begin
    inhibit = ~&output_spikes;
    taken   = 1'b0;
    fire    = '0;
    for (int unsigned n = 0; n < NEURONS; n++) begin
      if (cand[n] && !inhibit && !taken) begin
        fire[n] = 1'b1;
        taken   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    fire = cand;
  end
`endif

  // Lowest firing index. Scanning downward lets the lowest index win.
  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < NEURONS; i++) begin
      if (fire[NEURONS - 1 - i])
        win = WW'(NEURONS - 1 - i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active        <= '0;
      age           <= '0;
      pot           <= '0;
      output_spikes <= '1;
      fire_valid    <= 1'b0;
      winner_idx    <= '0;
    end else if (last) begin
      active        <= '0;
      age           <= '0;
      pot           <= '0;
      output_spikes <= '1;
      fire_valid    <= 1'b0;
    end else begin
      pot           <= sum;
      output_spikes <= output_spikes & ~fire;
      fire_valid    <= |fire;
      if (|fire)
        winner_idx <= win;
      for (int unsigned n = 0; n < NEURONS; n++) begin
        for (int unsigned s = 0; s < SYNAPSES; s++) begin
          if (active[n][s]) begin
            if (age[n][s] != AW'(TP - 1))
              age[n][s] <= age[n][s] + AW'(1);
          end else if (!input_spikes[n][s]) begin
            // age 0 is used this cycle, so the register starts at 1
            active[n][s] <= 1'b1;
            age[n][s]    <= AW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_srm_wta_column.sv
`ifndef TIME_PERIOD
`define TIME_PERIOD 8
`endif

module tb_srm_wta_column;
  localparam int TP = `TIME_PERIOD;
  localparam int N  = 2;
  localparam int S  = 2;
  localparam int TH = 4;
  localparam int AW = $clog2(TP);
  localparam int NS = N * S;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic [AW-1:0]                cycle = '0;
  logic [N-1:0][S-1:0]          input_spikes = '1;
  logic [N-1:0][S-1:0][TP-1:0]  weights = '0;
  logic [N-1:0]                 output_spikes;
  logic                         fire_valid;
  logic [0:0]                   winner_idx;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;

  logic [N-1:0][S-1:0] stim [TP];
  logic [N-1:0]        exp_out [TP];
  logic                exp_fv [TP];
  int                  exp_wi [TP];

  always #5 clk = ~clk;

  srm_wta_column #(
    .NEURONS   (N),
    .SYNAPSES  (S),
    .THRESHOLD (TH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cycle         (cycle),
    .input_spikes  (input_spikes),
    .weights       (weights),
    .output_spikes (output_spikes),
    .fire_valid    (fire_valid),
    .winner_idx    (winner_idx)
  );

  task automatic check(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
    end
  endtask

  // Potential contributed by one synapse k cycles after its spike arrived
  function automatic int resp(input logic [TP-1:0] w, input int k);
    int r = 0;
    for (int j = 0; j <= k && j < TP; j++) r += int'(w[j]);
    return r;
  endfunction

  function automatic logic [TP-1:0] therm(input int p);
    logic [TP:0] v;
    v = (TP+1)'((1 << p) - 1);
    return v[TP-1:0];
  endfunction

  // Expected outputs per cycle of one period, from arrival times and
  // closed-form responses. exp_*[c] is what is visible during cycle c.
  task automatic build_model();
    int t [N][S];
    logic [N-1:0] fired, meets, nf;
    int p, lo;
    fired = '0;
    for (int n = 0; n < N; n++)
      for (int s = 0; s < S; s++) t[n][s] = -1;
    exp_out[0] = '1; exp_fv[0] = 1'b0; exp_wi[0] = 0;
    for (int c = 0; c <= TP - 2; c++) begin
      for (int n = 0; n < N; n++)
        for (int s = 0; s < S; s++)
          if (t[n][s] < 0 && !stim[c][n][s]) t[n][s] = c;
      meets = '0;
      lo = -1;
      for (int n = 0; n < N; n++) begin
        p = 0;
        for (int s = 0; s < S; s++)
          if (t[n][s] >= 0) p += resp(weights[n][s], c - t[n][s]);
        meets[n] = (p >= TH) && !fired[n];
        if (meets[n] && lo < 0) lo = n;
      end
      nf = '0;
`ifdef SRM_WTA_EN
      if (lo >= 0 && fired == '0) nf[lo] = 1'b1;
`else
      nf = meets;
`endif
      fired = fired | nf;
      exp_out[c+1] = ~fired;
      exp_fv[c+1]  = |nf;
      exp_wi[c+1]  = (lo < 0) ? 0 : lo;
    end
  endtask

  task automatic run_cycles(input string tag, input int upto);
    for (int c = 0; c < upto; c++) begin
      @(posedge clk); #1;
      check(tag, "out", 32'(output_spikes), 32'(exp_out[c]));
      check(tag, "fv", 32'(fire_valid), 32'(exp_fv[c]));
      if (exp_fv[c]) check(tag, "idx", 32'(winner_idx), 32'(exp_wi[c]));
      if (fire_valid) pulses++;
      cycle        = AW'(c);
      input_spikes = stim[c];
    end
  endtask

  task automatic run_period(input string tag);
    build_model();
    run_cycles(tag, TP);
  endtask

  task automatic clear_stim();
    for (int c = 0; c < TP; c++) stim[c] = '1;
  endtask

  // Line low for cycles [lo, hi)
  task automatic spike(input int n, input int s, input int lo, input int hi);
    for (int c = lo; c < hi && c < TP; c++) stim[c][n][s] = 1'b0;
  endtask

  task automatic basic_setup(input bit both);
    weights = '0;
    clear_stim();
    for (int s = 0; s < S; s++) weights[0][s] = therm(2);
    spike(0, 0, 1, TP);
    spike(0, 1, 1, 2);
    if (both) begin
      for (int s = 0; s < S; s++) weights[1][s] = therm(2);
      spike(1, 0, 1, TP);
      spike(1, 1, 1, 2);
    end
  endtask

  initial begin
    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset", "out", 32'(output_spikes), 32'h3);
      check("reset", "fv", 32'(fire_valid), 32'h0);
      check("reset", "idx", 32'(winner_idx), 32'h0);
      input_spikes = NS'($urandom);
      cycle = AW'($urandom);
      for (int n = 0; n < N; n++)
        for (int s = 0; s < S; s++) weights[n][s] = TP'($urandom);
    end
    input_spikes = '1;
    cycle = AW'(TP - 1);
    rst_n = 1'b1;

    basic_setup(0);
    run_period("basic");
    run_period("basic2");

    weights = '0;
    for (int n = 0; n < N; n++)
      for (int s = 0; s < S; s++) weights[n][s] = therm(1);
    clear_stim();
    for (int n = 0; n < N; n++)
      for (int s = 0; s < S; s++) spike(n, s, 0, TP);
    run_period("subthr");

    basic_setup(1);
    run_period("tie");

    basic_setup(0);
    for (int s = 0; s < S; s++) weights[1][s] = therm(2);
    spike(1, 0, 4, TP);
    spike(1, 1, 4, TP);
    run_period("late");

    // Spike only in the last cycle, then a quiet period
    for (int n = 0; n < N; n++)
      for (int s = 0; s < S; s++) weights[n][s] = therm(TP);
    clear_stim();
    for (int n = 0; n < N; n++)
      for (int s = 0; s < S; s++) spike(n, s, TP - 1, TP);
    run_period("lastcyc");
    clear_stim();
    run_period("after_last");

    // Reset asserted in cycle 3 of an active period, while fire_valid is high
    basic_setup(0);
    build_model();
    run_cycles("midrst", 4);
    rst_n = 1'b0;
    #1;
    check("midrst", "out", 32'(output_spikes), 32'h3);
    check("midrst", "fv", 32'(fire_valid), 32'h0);
    for (int c = 4; c < TP; c++) begin
      @(posedge clk); #1;
      check("midrst_hold", "out", 32'(output_spikes), 32'h3);
      check("midrst_hold", "fv", 32'(fire_valid), 32'h0);
      cycle = AW'(c);
      input_spikes = stim[c];
    end
    rst_n = 1'b1;

    basic_setup(0);
    pulses = 0;
    for (int k = 0; k < 75; k++) run_period("b2b");
    @(posedge clk); #1;
    check("b2b_end", "out", 32'(output_spikes), 32'h3);
    check("b2b", "pulses", 32'(pulses), 32'd75);
    cycle = '0;
    input_spikes = stim[0];

    // Random periods: thermometer weights, random arrival times
    for (int k = 0; k < 40; k++) begin
      clear_stim();
      for (int n = 0; n < N; n++)
        for (int s = 0; s < S; s++) begin
          int t;
          weights[n][s] = therm(int'($urandom_range(TP, 0)));
          t = int'($urandom_range(TP, 0));
          for (int c = t; c < TP; c++)
            stim[c][n][s] = (c == t) ? 1'b0 : 1'($urandom);
        end
      run_period("rand");
    end

    @(posedge clk); #1;
    check("final", "out", 32'(output_spikes), 32'h3);
    check("final", "fv", 32'(fire_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
